// File: rtl/aes_spi_master.sv
// -----------------------------------------------------------------------------
// aes_spi_master
//
// Host-side SPI master for the AES decryption slave. A parallel start/done
// request carries a key, its size code and one 128-bit ciphertext block. The
// master sends two 258-bit frames ({key_size, key} and the zero-padded
// ciphertext). Between frames it keeps sclk running with cs low, so the slave,
// which is clocked only by sclk, can finish key expansion and the inverse
// cipher. A third, all-zero frame clocks the plaintext back in.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          one-cycle request, only looked at while idle
//   key_size[1:0]  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal (err)
//   key[255:0]     key, left-justified
//   ciphertext     128-bit block to decrypt
//   busy           high from the cycle after an accepted start until done
//   done           one-cycle completion pulse; plaintext/err valid
//   err            illegal key_size flag, held until the next accepted start
//   plaintext      received block, held until the next done
//   cs, sclk, sdi  SPI outputs (cs active high, sclk idle low, MSB first)
//   sdo            SPI data from the slave, sampled on sclk rising edges
// -----------------------------------------------------------------------------
module aes_spi_master #(
   parameter int CLK_DIV  = 4,    // clk cycles per sclk half-period (>= 1)
   parameter int FRAME_W  = 258,  // bits per SPI frame (>= 258)
   parameter int GAP_SCLK = 64    // sclk periods between frames
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_size,
   input  logic [255:0] key,
   input  logic [127:0] ciphertext,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [127:0] plaintext,
   output logic         cs,
   output logic         sclk,
   output logic         sdi,
   input  logic         sdo
);

   localparam int DIV_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_CW = ($clog2(FRAME_W) > 9) ? $clog2(FRAME_W) : 9;
   localparam int GAP_CW = ($clog2(GAP_SCLK + 1) > 8) ? $clog2(GAP_SCLK + 1) : 8;

   localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(CLK_DIV - 1);
   localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(FRAME_W - 1);
   localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_SCLK - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_GAP,
      S_FIN
   } state_t;

   // control state
   state_t              r_state;
   logic [1:0]          r_frame;
   logic [DIV_CW-1:0]   r_div;
   logic [BIT_CW-1:0]   r_bit_cnt;
   logic [GAP_CW-1:0]   r_gap_cnt;
   logic                r_last;     // final sclk fall of the frame has happened
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic [127:0]        r_pt;
   logic                r_cs;
   logic                r_sclk;
   logic                r_sdi;

   // datapath (no reset needed: always written before being used)
   logic [1:0]          r_key_size;
   logic [255:0]        r_key;
   logic [127:0]        r_ct;
   logic [FRAME_W-1:0]  r_sr;
   logic [FRAME_W-1:0]  r_rx;

   logic                w_div_wrap;
   logic                w_in_shift;
   logic                w_sclk_rise;
   logic                w_shift_adv;
   logic                w_accept;
   logic [FRAME_W-1:0]  w_load;

   assign w_div_wrap  = (r_div == DIV_LAST);
   assign w_in_shift  = (r_state == S_SHIFT);
   // Rising sclk edge inside a frame: this is where sdo is captured.
   assign w_sclk_rise = w_in_shift && w_div_wrap && !r_sclk && !r_last;
   // Falling sclk edge that still has a bit to present: sdi moves only here,
   // a full half-period ahead of the next rise.
   assign w_shift_adv = w_in_shift && w_div_wrap && r_sclk && (r_bit_cnt != BIT_LAST);
   assign w_accept    = (r_state == S_IDLE) && start && (key_size != 2'b11);

   // Frame contents, selected by frame index; frame 2 only clocks data back.
   always_comb begin
      w_load = '0;
      case (r_frame)
         2'd0:    w_load = FRAME_W'({r_key_size, r_key}) << (FRAME_W - 258);
         2'd1:    w_load = FRAME_W'(r_ct);
         default: w_load = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_key_size <= key_size;
         r_key      <= key;
         r_ct       <= ciphertext;
      end
      if (r_state == S_LOAD) begin
         r_sr <= w_load;
      end else if (w_shift_adv) begin
         r_sr <= {r_sr[FRAME_W-2:0], 1'b0};
      end
      if (w_sclk_rise) begin
         r_rx <= {r_rx[FRAME_W-2:0], sdo};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_frame   <= '0;
         r_div     <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_last    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_pt      <= '0;
         r_cs      <= 1'b0;
         r_sclk    <= 1'b0;
         r_sdi     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (key_size == 2'b11) begin
                     // Illegal size: skip the SPI traffic, report through FIN.
                     r_err   <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_err   <= 1'b0;
                     r_frame <= 2'd0;
                     r_state <= S_LOAD;
                  end
               end
            end

            S_LOAD: begin
               r_sdi     <= w_load[FRAME_W-1];
               r_cs      <= 1'b1;
               r_div     <= '0;
               r_bit_cnt <= '0;
               r_last    <= 1'b0;
               r_state   <= S_SHIFT;
            end

            S_SHIFT: begin
               r_div <= w_div_wrap ? '0 : r_div + DIV_CW'(1);
               if (w_div_wrap) begin
                  if (r_sclk) begin
                     r_sclk <= 1'b0;
                     if (r_bit_cnt == BIT_LAST) begin
                        r_last <= 1'b1;
                        r_sdi  <= 1'b0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                        r_sdi     <= r_sr[FRAME_W-2];
                     end
                  end else if (r_last) begin
                     // One half-period after the final fall: close the frame.
                     r_cs      <= 1'b0;
                     r_last    <= 1'b0;
                     r_bit_cnt <= '0;
                     r_state   <= (r_frame == 2'd2) ? S_FIN : S_GAP;
                  end else begin
                     r_sclk <= 1'b1;
                  end
               end
            end

            S_GAP: begin
               r_sdi <= 1'b0;
               r_div <= w_div_wrap ? '0 : r_div + DIV_CW'(1);
               if (w_div_wrap) begin
                  if (r_sclk) begin
                     r_sclk <= 1'b0;
                     // A gap period is counted on its falling edge.
                     if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_frame   <= r_frame + 2'd1;
                        r_state   <= S_LOAD;
                     end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_CW'(1);
                     end
                  end else begin
                     r_sclk <= 1'b1;
                  end
               end
            end

            S_FIN: begin
               // The first 128 bits received in frame 2 sit at the top.
               if (!r_err) begin
                  r_pt <= r_rx[FRAME_W-1 -: 128];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign plaintext = r_pt;
   assign cs        = r_cs;
   assign sclk      = r_sclk;
   assign sdi       = r_sdi;

endmodule

// File: tb/tb_aes_spi_master.sv
// -----------------------------------------------------------------------------
// tb_aes_spi_master
//
// Bench for aes_spi_master. A slave stand-in collects the sdi bit stream of
// every cs window, measures frame and gap timing, and answers frame 2 with a
// chosen plaintext on sdo. Expected frames, latency and results are computed
// from the request fields with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_aes_spi_master;

   localparam int CLK_DIV    = 4;
   localparam int FRAME_W    = 258;
   localparam int GAP_SCLK   = 64;
   localparam int FRAME_CLKS = (2 * FRAME_W + 1) * CLK_DIV;
   localparam int LAT_REF    = 3 * FRAME_CLKS + 2 * (2 * GAP_SCLK * CLK_DIV) + 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   key_size = 2'b00;
   logic [255:0] key = '0;
   logic [127:0] ciphertext = '0;
   logic         busy, done, err;
   logic [127:0] plaintext;
   logic         cs, sclk, sdi;
   logic         sdo = 1'b0;

   aes_spi_master #(
      .CLK_DIV  (CLK_DIV),
      .FRAME_W  (FRAME_W),
      .GAP_SCLK (GAP_SCLK)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_size   (key_size),
      .key        (key),
      .ciphertext (ciphertext),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .plaintext  (plaintext),
      .cs         (cs),
      .sclk       (sclk),
      .sdi        (sdi),
      .sdo        (sdo)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // slave / monitor state
   logic [FRAME_W-1:0] frm_data [3];
   int                 frm_bits [3];
   int                 frm_len  [3];
   int                 fcount     = 0;
   int                 gap_rises  = 0;
   int                 sclk_edges = 0;
   int                 done_cnt   = 0;
   int                 cur_bits   = 0;
   int                 cur_len    = 0;
   logic [FRAME_W-1:0] cur_data   = '0;
   logic [FRAME_W-1:0] tx_word    = '0;
   logic [FRAME_W-1:0] resp_f2    = '0;
   logic               prev_cs    = 1'b0;
   logic               prev_sclk  = 1'b0;

   task automatic check_val(input string tag, input logic [FRAME_W-1:0] got,
                            input logic [FRAME_W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [287:0] rnd288();
      logic [287:0] w;
      for (int i = 0; i < 9; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Returns the measured latency when inside the tolerance, else the target,
   // so a miss prints the measured and required numbers.
   function automatic int lat_exp(input int lat, input int ref_v, input int tol);
      if (lat >= ref_v - tol && lat <= ref_v + tol) return lat;
      return ref_v;
   endfunction

   // Slave stand-in and bus monitor, sampled 1 time unit after each clk edge.
   initial begin
      logic [287:0] r;
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (sclk !== prev_sclk) sclk_edges++;
         if (done === 1'b1) done_cnt++;
         if (cs && !prev_cs) begin
            cur_bits = 0;
            cur_len  = 0;
            cur_data = '0;
            r        = rnd288();
            tx_word  = (fcount == 2) ? resp_f2 : r[FRAME_W-1:0];
            sdo      = tx_word[FRAME_W-1];
         end
         if (cs) cur_len++;
         if (cs && sclk && !prev_sclk) begin
            cur_data = {cur_data[FRAME_W-2:0], sdi};
            cur_bits++;
         end
         if (cs && !sclk && prev_sclk && cur_bits < FRAME_W) sdo = tx_word[FRAME_W-1-cur_bits];
         if (!cs && sclk && !prev_sclk) gap_rises++;
         if (!cs && prev_cs) begin
            if (fcount < 3) begin
               frm_data[fcount] = cur_data;
               frm_bits[fcount] = cur_bits;
               frm_len[fcount]  = cur_len;
            end
            fcount++;
         end
         prev_cs   = cs;
         prev_sclk = sclk;
      end
   end

   // mode 0: plain request, 1: start spammed during busy, 2: reset in frame 1
   task automatic run_txn(input string nm, input logic [1:0] ks, input logic [255:0] k,
                          input logic [127:0] c, input logic [127:0] p, input int mode);
      int           lat, e0, d0;
      bit           seen, aborted;
      logic [127:0] pt0;
      logic [287:0] r;
      @(negedge clk);
      r          = rnd288();
      key_size   = ks;
      key        = k;
      ciphertext = c;
      resp_f2    = {p, r[129:0]};
      fcount     = 0;
      gap_rises  = 0;
      e0         = sclk_edges;
      d0         = done_cnt;
      pt0        = plaintext;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      lat     = 0;
      seen    = 1'b0;
      aborted = 1'b0;
      while (!seen && !aborted && lat < 10000) begin
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (lat == 1) check_val({nm, "/busy_hi"}, FRAME_W'(busy), FRAME_W'(1));
            if (mode == 1 && lat < 7000 && (lat % 37) == 5) begin
               r          = rnd288();
               start      = 1'b1;
               key        = r[255:0];
               ciphertext = r[287:160];
               key_size   = r[1:0];
            end
            if (mode == 2 && fcount == 1 && cs && cur_bits >= 100) begin
               rst_n   = 1'b0;
               aborted = 1'b1;
            end
         end
      end

      if (mode == 2) begin
         check_val({nm, "/abort_reached"}, FRAME_W'(aborted), FRAME_W'(1));
         #1;
         check_val({nm, "/rst_cs"},   FRAME_W'(cs),   '0);
         check_val({nm, "/rst_sclk"}, FRAME_W'(sclk), '0);
         check_val({nm, "/rst_sdi"},  FRAME_W'(sdi),  '0);
         check_val({nm, "/rst_busy"}, FRAME_W'(busy), '0);
         @(negedge clk);
         e0 = sclk_edges;
         repeat (6) begin
            @(negedge clk);
            start = 1'($urandom);
            sdo   = 1'($urandom);
         end
         start = 1'b0;
         check_val({nm, "/rst_no_sclk"}, FRAME_W'(sclk_edges - e0), '0);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (40) @(negedge clk);
         check_val({nm, "/no_done"}, FRAME_W'(done_cnt - d0), '0);
         check_val({nm, "/pt_clear"}, FRAME_W'(plaintext), '0);
         return;
      end

      check_val({nm, "/done_seen"}, FRAME_W'(seen), FRAME_W'(1));
      if (ks == 2'b11) begin
         check_val({nm, "/latency"}, FRAME_W'(lat), FRAME_W'(lat_exp(lat, 2, 1)));
         check_val({nm, "/err"}, FRAME_W'(err), FRAME_W'(1));
         check_val({nm, "/no_frames"}, FRAME_W'(fcount), '0);
         check_val({nm, "/no_sclk"}, FRAME_W'(sclk_edges - e0), '0);
         check_val({nm, "/pt_held"}, FRAME_W'(plaintext), FRAME_W'(pt0));
      end else begin
         check_val({nm, "/latency"}, FRAME_W'(lat), FRAME_W'(lat_exp(lat, LAT_REF, 2)));
         check_val({nm, "/plaintext"}, FRAME_W'(plaintext), FRAME_W'(p));
         check_val({nm, "/err"}, FRAME_W'(err), '0);
         check_val({nm, "/busy_lo"}, FRAME_W'(busy), '0);
         check_val({nm, "/frames"}, FRAME_W'(fcount), FRAME_W'(3));
         check_val({nm, "/frame0"}, frm_data[0], {ks, k});
         check_val({nm, "/frame1"}, frm_data[1], FRAME_W'(c));
         check_val({nm, "/frame2"}, frm_data[2], '0);
         for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s/bits%0d", nm, i), FRAME_W'(frm_bits[i]), FRAME_W'(FRAME_W));
            check_val($sformatf("%s/cs_len%0d", nm, i), FRAME_W'(frm_len[i]), FRAME_W'(FRAME_CLKS));
         end
         check_val({nm, "/gap_rises"}, FRAME_W'(gap_rises), FRAME_W'(2 * GAP_SCLK));
      end
      @(posedge clk);
      #1;
      check_val({nm, "/done_pulse"}, FRAME_W'(done), '0);
      repeat (20) @(posedge clk);
      #1;
      check_val({nm, "/done_count"}, FRAME_W'(done_cnt - d0), FRAME_W'(1));
      check_val({nm, "/idle_busy"}, FRAME_W'(busy), '0);
      check_val({nm, "/err_hold"}, FRAME_W'(err), FRAME_W'(ks == 2'b11));
   endtask

   initial begin
      logic [287:0] r;
      logic [127:0] c1_key, c1_ct, fips_pt;
      logic [255:0] c3_key;
      logic [127:0] c3_ct;
      c1_key  = 128'h000102030405060708090a0b0c0d0e0f;
      c1_ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      c3_key  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      c3_ct   = 128'h8ea2b7ca516745bfeafc49904b496089;
      fips_pt = 128'h00112233445566778899aabbccddeeff;

      #1 rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start    = 1'($urandom);
         sdo      = 1'($urandom);
         key_size = 2'($urandom);
      end
      @(negedge clk);
      check_val("reset/busy", FRAME_W'(busy), '0);
      check_val("reset/done", FRAME_W'(done), '0);
      check_val("reset/err", FRAME_W'(err), '0);
      check_val("reset/plaintext", FRAME_W'(plaintext), '0);
      check_val("reset/cs", FRAME_W'(cs), '0);
      check_val("reset/sclk", FRAME_W'(sclk), '0);
      check_val("reset/sdi", FRAME_W'(sdi), '0);
      check_val("reset/sclk_still", FRAME_W'(sclk_edges), '0);
      start = 1'b0;
      sdo   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      r = rnd288();
      run_txn("c1", 2'b00, {c1_key, r[127:0]}, c1_ct, fips_pt, 0);
      run_txn("c3", 2'b10, c3_key, c3_ct, fips_pt, 0);
      r = rnd288();
      run_txn("illegal", 2'b11, r[255:0], r[287:160], r[127:0], 0);
      r = rnd288();
      run_txn("spam", 2'($urandom_range(0, 2)), r[255:0], r[287:160], r[159:32], 1);
      for (int i = 0; i < 2; i++) begin
         r = rnd288();
         run_txn($sformatf("rand%0d", i), 2'($urandom_range(0, 2)), r[255:0], r[287:160],
                 r[191:64], 0);
      end
      r = rnd288();
      run_txn("abort", 2'b00, {c1_key, r[127:0]}, c1_ct, fips_pt, 2);
      r = rnd288();
      run_txn("retry", 2'b00, {c1_key, r[127:0]}, c1_ct, fips_pt, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
